// File: rtl/x4_spi_master.sv
// Byte-wide SPI master (mode 0) that turns one write/read request into a 16-bit frame to the X4.
// Optional build macro X4_SPI_LATE_SAMPLE_EN moves MISO sampling to the falling SCLK edge.
module x4_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 4,
    parameter int CS_HOLD    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk_100m,
    input  logic       rst,
    input  logic       write_spi_en,
    input  logic [7:0] write_spi_addr,
    input  logic [7:0] write_spi_data,
    output logic       write_spi_done,
    input  logic       read_spi_en,
    input  logic [7:0] read_spi_addr,
    output logic [7:0] read_spi_data,
    output logic       read_spi_done,
    output logic       spi_busy,
    output logic       spi_csn,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);
    localparam int MAX_WAIT = (CS_SETUP > CS_HOLD)
                            ? ((CS_SETUP > GAP_CYCLES) ? CS_SETUP : GAP_CYCLES)
                            : ((CS_HOLD > GAP_CYCLES) ? CS_HOLD : GAP_CYCLES);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_phase;     // 0: SCLK low half of a bit, 1: high half
    logic [3:0]       r_bit_cnt;
    logic [14:0]      r_tx;        // frame bits still to be presented on MOSI
    logic [7:0]       r_rx;
    logic             r_rw;
    logic             r_csn, r_sclk, r_mosi, r_busy, r_wdone, r_rdone;
    logic [7:0]       r_rdata;

    logic [15:0] w_frame_write, w_frame_read;
    logic        w_rise, w_fall, w_sample, w_unused;

    // Address bit 7 carries no meaning on the X4 side; the frame uses bit 15 for rw.
    assign w_frame_write = {1'b0, write_spi_addr[6:0], write_spi_data};
    assign w_frame_read  = {1'b1, read_spi_addr[6:0], 8'h00};
    assign w_unused      = write_spi_addr[7] ^ read_spi_addr[7];

    assign w_rise = (r_state == S_SHIFT) && !r_phase && (r_div == DIV_LAST);
    assign w_fall = (r_state == S_SHIFT) &&  r_phase && (r_div == DIV_LAST);

`ifdef X4_SPI_LATE_SAMPLE_EN
    assign w_sample = w_fall;
`else
    assign w_sample = w_rise;
`endif

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_phase   <= 1'b0;
            r_bit_cnt <= 4'd0;
            r_tx      <= '0;
            r_rx      <= 8'h00;
            r_rw      <= 1'b0;
            r_csn     <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_wdone   <= 1'b0;
            r_rdone   <= 1'b0;
            r_rdata   <= 8'h00;
        end else begin
            r_wdone <= 1'b0;
            r_rdone <= 1'b0;
            if (w_sample && r_rw)
                r_rx <= {r_rx[6:0], spi_miso};

            case (r_state)
                S_IDLE: begin
                    // Write has priority; a concurrent read stays pending on its level enable.
                    if (write_spi_en) begin
                        r_rw    <= 1'b0;
                        r_tx    <= w_frame_write[14:0];
                        r_mosi  <= w_frame_write[15];
                        r_csn   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end else if (read_spi_en) begin
                        r_rw    <= 1'b1;
                        r_tx    <= w_frame_read[14:0];
                        r_mosi  <= w_frame_read[15];
                        r_csn   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt     <= '0;
                        r_div     <= '0;
                        r_phase   <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_rise) begin
                        r_div   <= '0;
                        r_phase <= 1'b1;
                        r_sclk  <= 1'b1;
                    end else if (w_fall) begin
                        r_div     <= '0;
                        r_phase   <= 1'b0;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd15) begin
                            r_mosi  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_HOLD;
                        end else begin
                            r_mosi <= r_tx[14];
                            r_tx   <= {r_tx[13:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_csn   <= 1'b1;
                        r_state <= S_DONE;
                        if (r_rw) begin
                            r_rdone <= 1'b1;
                            r_rdata <= r_rx;
                        end else begin
                            r_wdone <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign write_spi_done = r_wdone;
    assign read_spi_done  = r_rdone;
    assign read_spi_data  = r_rdata;
    assign spi_busy       = r_busy;
    assign spi_csn        = r_csn;
    assign spi_sclk       = r_sclk;
    assign spi_mosi       = r_mosi;
endmodule

// File: tb/tb_x4_spi_master.sv
// Randomised scoreboard bench for x4_spi_master: expected frames/done events are queued at issue
// and a negedge monitor pops and compares them; an SPI slave model answers reads.
module tb_x4_spi_master;
    localparam int CLK_DIV    = 4;
    localparam int CS_SETUP   = 4;
    localparam int CS_HOLD    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int LAT        = 1 + CS_SETUP + 32 * CLK_DIV + CS_HOLD;   // 137
    localparam int CSN_LOW    = CS_SETUP + 32 * CLK_DIV + CS_HOLD;       // 136
`ifdef X4_SPI_LATE_SAMPLE_EN
    localparam bit LATE_BUILD = 1'b1;
`else
    localparam bit LATE_BUILD = 1'b0;
`endif

    logic       clk_100m = 1'b0;
    logic       rst = 1'b1;
    logic       write_spi_en = 1'b0;
    logic [7:0] write_spi_addr = 8'h00;
    logic [7:0] write_spi_data = 8'h00;
    logic       write_spi_done;
    logic       read_spi_en = 1'b0;
    logic [7:0] read_spi_addr = 8'h00;
    logic [7:0] read_spi_data;
    logic       read_spi_done;
    logic       spi_busy, spi_csn, spi_sclk, spi_mosi;
    logic       spi_miso = 1'b0;

    x4_spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                    .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk_100m(clk_100m), .rst(rst),
        .write_spi_en(write_spi_en), .write_spi_addr(write_spi_addr),
        .write_spi_data(write_spi_data), .write_spi_done(write_spi_done),
        .read_spi_en(read_spi_en), .read_spi_addr(read_spi_addr),
        .read_spi_data(read_spi_data), .read_spi_done(read_spi_done),
        .spi_busy(spi_busy), .spi_csn(spi_csn), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk_100m = ~clk_100m;

    int cyc = 0;
    always @(posedge clk_100m) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    typedef struct {
        bit         rd;
        logic [7:0] data;
        int         at;
    } done_t;

    done_t       done_q[$];
    logic [15:0] frame_q[$];
    logic [7:0]  model_rdata = 8'h00;
    bit          abort_pending = 1'b0;

    // Slave: mode 0 answers {8'h00, byte}; "late" variant shifts its output half a bit later.
    logic [7:0]  slave_byte = 8'h00;
    bit          slave_late = 1'b0;
    logic [15:0] s_resp = 16'h0;
    int          s_k = 0;
    logic        s_prev_csn = 1'b1, s_prev_sclk = 1'b0;

    always @(spi_csn or spi_sclk) begin
        if (s_prev_csn && !spi_csn) begin
            s_resp   = {8'h00, slave_byte};
            s_k      = 0;
            spi_miso = slave_late ? 1'b0 : s_resp[15];
        end else if (!spi_csn && (spi_sclk != s_prev_sclk)) begin
            if (spi_sclk && slave_late) begin
                if (s_k < 16) spi_miso = s_resp[15 - s_k];
                s_k++;
            end else if (!spi_sclk && !slave_late) begin
                s_k++;
                if (s_k < 16) spi_miso = s_resp[15 - s_k];
            end
        end
        s_prev_csn  = spi_csn;
        s_prev_sclk = spi_sclk;
    end

    // Monitor: sampled on the falling clk edge, pops expectations as the DUT produces events.
    logic [15:0] m_cap = 16'h0;
    int          m_bits = 0, m_low = 0;
    logic        m_prev_csn = 1'b1, m_prev_sclk = 1'b0;

    always @(negedge clk_100m) begin
        if (!rst) begin
            if (!spi_csn) begin
                m_low++;
                if (spi_sclk && !m_prev_sclk) begin
                    m_cap = {m_cap[14:0], spi_mosi};
                    m_bits++;
                end
            end
            if (spi_csn && !m_prev_csn) begin
                if (!abort_pending) begin
                    chk("frame_expected", frame_q.size() > 0, 1);
                    if (frame_q.size() > 0) begin
                        logic [15:0] ef;
                        ef = frame_q.pop_front();
                        chk("mosi_frame", m_cap, ef);
                        chk("sclk_rises", m_bits, 16);
                        chk("csn_low_cycles", m_low, CSN_LOW);
                    end
                end
                m_cap = 16'h0; m_bits = 0; m_low = 0;
            end
            if (write_spi_done || read_spi_done) begin
                chk("done_onehot", write_spi_done & read_spi_done, 0);
                chk("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_kind_read", read_spi_done, e.rd);
                    chk("done_cycle", cyc, e.at);
                    chk("read_spi_data", read_spi_data, e.data);
                end
            end
        end else begin
            m_cap = 16'h0; m_bits = 0; m_low = 0;
        end
        m_prev_csn  = spi_csn;
        m_prev_sclk = spi_sclk;
    end

    // Reference: frame layout, read result (late slave seen one bit late unless late sampling).
    task automatic expect_txn(input bit rd, input logic [7:0] addr, input logic [7:0] data,
                              input logic [7:0] resp, input bit late, input int at);
        if (rd) begin
            frame_q.push_back({1'b1, addr[6:0], 8'h00});
            model_rdata = (late && !LATE_BUILD) ? (resp >> 1) : resp;
        end else begin
            frame_q.push_back({1'b0, addr[6:0], data});
        end
        done_q.push_back('{rd, model_rdata, at});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (spi_busy && n < 400) begin @(negedge clk_100m); n++; end
        if (spi_busy) chk("idle_timeout", spi_busy, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((done_q.size() > 0 || frame_q.size() > 0) && n < 700) begin
            @(negedge clk_100m); n++;
        end
        chk("drain", done_q.size() + frame_q.size(), 0);
        done_q.delete();
        frame_q.delete();
    endtask

    task automatic do_txn(input bit rd, input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] resp, input bit late);
        wait_idle();
        slave_byte = resp;
        slave_late = late;
        expect_txn(rd, addr, data, resp, late, cyc + LAT);
        if (rd) begin read_spi_addr = addr; read_spi_en = 1'b1; end
        else begin write_spi_addr = addr; write_spi_data = data; write_spi_en = 1'b1; end
        @(negedge clk_100m);
        write_spi_en = 1'b0;
        read_spi_en  = 1'b0;
        $display("txn %s addr=%02h data=%02h resp=%02h late=%0d expect_rdata=%02h",
                 rd ? "read " : "write", addr, data, resp, late, model_rdata);
        wait_drain();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_100m);
        rst = 1'b0;
        @(negedge clk_100m);
        chk("rst_csn", spi_csn, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", spi_busy, 0);
        chk("rst_dones", {write_spi_done, read_spi_done}, 0);
        chk("rst_rdata", read_spi_data, 8'h00);

        do_txn(1'b0, 8'h55, 8'h12, 8'h00, 1'b0);
        do_txn(1'b1, 8'h82, 8'h00, 8'hA5, 1'b0);
        do_txn(1'b0, 8'h13, 8'hC7, 8'h00, 1'b0);
        chk("rdata_held", read_spi_data, 8'hA5);

        // Simultaneous write and read requests: write first, read after the gap.
        wait_idle();
        slave_byte = 8'h6E;
        slave_late = 1'b0;
        expect_txn(1'b0, 8'h21, 8'h9B, 8'h00, 1'b0, cyc + LAT);
        expect_txn(1'b1, 8'hF4, 8'h00, 8'h6E, 1'b0, cyc + LAT + 1 + GAP_CYCLES + LAT);
        write_spi_addr = 8'h21; write_spi_data = 8'h9B; read_spi_addr = 8'hF4;
        write_spi_en = 1'b1; read_spi_en = 1'b1;
        for (int i = 0; i < 300 && !write_spi_done; i++) @(negedge clk_100m);
        write_spi_en = 1'b0;
        for (int i = 0; i < 300 && !read_spi_done; i++) @(negedge clk_100m);
        read_spi_en = 1'b0;
        $display("txn write+read pair, write first then read expect_rdata=%02h", model_rdata);
        wait_drain();

        // Read pulse during a write frame must be ignored.
        wait_idle();
        slave_late = 1'b0;
        expect_txn(1'b0, 8'h40, 8'h5A, 8'h00, 1'b0, cyc + LAT);
        write_spi_addr = 8'h40; write_spi_data = 8'h5A; write_spi_en = 1'b1;
        @(negedge clk_100m);
        write_spi_en = 1'b0;
        repeat (50) @(negedge clk_100m);
        read_spi_addr = 8'h33; read_spi_en = 1'b1;
        @(negedge clk_100m);
        read_spi_en = 1'b0;
        $display("txn write with ignored read pulse");
        wait_drain();
        repeat (GAP_CYCLES + 20) @(negedge clk_100m);
        chk("ignored_read_idle", spi_busy, 0);

        // Reset in the middle of a read frame (bit 9).
        wait_idle();
        slave_byte = 8'hE1;
        read_spi_addr = 8'h07; read_spi_en = 1'b1;
        @(negedge clk_100m);
        read_spi_en = 1'b0;
        repeat (79) @(negedge clk_100m);
        abort_pending = 1'b1;
        rst = 1'b1;
        @(negedge clk_100m);
        rst = 1'b0;
        model_rdata = 8'h00;
        chk("abort_csn", spi_csn, 1);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_busy", spi_busy, 0);
        chk("abort_rdata", read_spi_data, 8'h00);
        repeat (LAT + 10) @(negedge clk_100m);
        abort_pending = 1'b0;
        $display("txn read aborted by reset");
        do_txn(1'b1, 8'h07, 8'h00, 8'hE1, 1'b0);

        // Slave answering half a bit late.
        do_txn(1'b1, 8'h11, 8'h00, 8'h3C, 1'b1);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] a, d, r;
            a = 8'($urandom);
            d = 8'($urandom);
            r = 8'($urandom);
            do_txn(1'($urandom_range(0, 1)), a, d, r, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
